// File: rtl/vga_timing_generator.sv
// VGA timing generator and DAC output stage; define VGA_TEST_PATTERN_EN for the colour-bar source.
// Latency: coordinates/markers 0, DAC outputs PIXEL_LATENCY+1 enabled ticks behind the counters.
// No backpressure: pixel_enable low freezes all state, video_enable low clears it.
module vga_timing_generator #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FRONT_PORCH   = 16,
    parameter int H_SYNC_PULSE    = 96,
    parameter int H_BACK_PORCH    = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FRONT_PORCH   = 10,
    parameter int V_SYNC_PULSE    = 2,
    parameter int V_BACK_PORCH    = 33,
    parameter bit H_SYNC_POLARITY = 1'b0,
    parameter bit V_SYNC_POLARITY = 1'b0,
    parameter int COLOR_WIDTH     = 8,
    parameter int COUNTER_WIDTH   = 10,
    parameter int PIXEL_LATENCY   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pixel_enable,
    input  logic                     video_enable,
    input  logic [COLOR_WIDTH-1:0]   pixel_red,
    input  logic [COLOR_WIDTH-1:0]   pixel_green,
    input  logic [COLOR_WIDTH-1:0]   pixel_blue,
    input  logic                     test_pattern_select,
    output logic [COUNTER_WIDTH-1:0] pixel_x_pos,
    output logic [COUNTER_WIDTH-1:0] pixel_y_pos,
    output logic                     pixel_request,
    output logic                     line_start,
    output logic                     frame_start,
    output logic [COLOR_WIDTH-1:0]   vga_red,
    output logic [COLOR_WIDTH-1:0]   vga_green,
    output logic [COLOR_WIDTH-1:0]   vga_blue,
    output logic                     vga_clock,
    output logic                     vga_horizontal_sync,
    output logic                     vga_vertical_sync,
    output logic                     vga_blank,
    output logic                     vga_sync
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

    localparam logic [COUNTER_WIDTH-1:0] H_LAST       = COUNTER_WIDTH'(H_TOTAL - 1);
    localparam logic [COUNTER_WIDTH-1:0] V_LAST       = COUNTER_WIDTH'(V_TOTAL - 1);
    localparam logic [COUNTER_WIDTH-1:0] H_ACT        = COUNTER_WIDTH'(H_ACTIVE);
    localparam logic [COUNTER_WIDTH-1:0] V_ACT        = COUNTER_WIDTH'(V_ACTIVE);
    localparam logic [COUNTER_WIDTH-1:0] H_SYNC_START = COUNTER_WIDTH'(H_ACTIVE + H_FRONT_PORCH);
    localparam logic [COUNTER_WIDTH-1:0] H_SYNC_END   = COUNTER_WIDTH'(H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [COUNTER_WIDTH-1:0] V_SYNC_START = COUNTER_WIDTH'(V_ACTIVE + V_FRONT_PORCH);
    localparam logic [COUNTER_WIDTH-1:0] V_SYNC_END   = COUNTER_WIDTH'(V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE);

    logic [COUNTER_WIDTH-1:0] x_counter;
    logic [COUNTER_WIDTH-1:0] y_counter;
    logic                     active;
    logic                     hsync_region;
    logic                     vsync_region;
    logic                     act_d;
    logic                     hs_d;
    logic                     vs_d;
    logic [COLOR_WIDTH-1:0]   src_red;
    logic [COLOR_WIDTH-1:0]   src_green;
    logic [COLOR_WIDTH-1:0]   src_blue;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_counter <= '0;
            y_counter <= '0;
        end else if (!video_enable) begin
            x_counter <= '0;
            y_counter <= '0;
        end else if (pixel_enable) begin
            if (x_counter == H_LAST) begin
                x_counter <= '0;
                y_counter <= (y_counter == V_LAST) ? '0 : y_counter + COUNTER_WIDTH'(1);
            end else begin
                x_counter <= x_counter + COUNTER_WIDTH'(1);
            end
        end
    end

    assign active       = (x_counter < H_ACT) && (y_counter < V_ACT);
    assign hsync_region = (x_counter >= H_SYNC_START) && (x_counter < H_SYNC_END);
    assign vsync_region = (y_counter >= V_SYNC_START) && (y_counter < V_SYNC_END);

    assign pixel_x_pos   = active ? x_counter : '0;
    assign pixel_y_pos   = active ? y_counter : '0;
    assign pixel_request = active;
    assign line_start    = pixel_enable && video_enable && (x_counter == '0);
    assign frame_start   = pixel_enable && video_enable && (x_counter == '0) && (y_counter == '0);
    assign vga_clock     = clock;

`ifdef VGA_TEST_PATTERN_EN
    logic [COUNTER_WIDTH-1:0] x_d;
`endif

    // Region flags (and x for the bar source) follow the framebuffer read latency.
    generate
        if (PIXEL_LATENCY == 0) begin : g_no_delay
            assign act_d = active;
            assign hs_d  = hsync_region;
            assign vs_d  = vsync_region;
`ifdef VGA_TEST_PATTERN_EN
            assign x_d   = x_counter;
`endif
        end else begin : g_delay
            logic [PIXEL_LATENCY-1:0] act_sr;
            logic [PIXEL_LATENCY-1:0] hs_sr;
            logic [PIXEL_LATENCY-1:0] vs_sr;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    act_sr <= '0;
                    hs_sr  <= '0;
                    vs_sr  <= '0;
                end else if (!video_enable) begin
                    act_sr <= '0;
                    hs_sr  <= '0;
                    vs_sr  <= '0;
                end else if (pixel_enable) begin
                    act_sr <= PIXEL_LATENCY'({act_sr, active});
                    hs_sr  <= PIXEL_LATENCY'({hs_sr, hsync_region});
                    vs_sr  <= PIXEL_LATENCY'({vs_sr, vsync_region});
                end
            end

            assign act_d = act_sr[PIXEL_LATENCY-1];
            assign hs_d  = hs_sr[PIXEL_LATENCY-1];
            assign vs_d  = vs_sr[PIXEL_LATENCY-1];

`ifdef VGA_TEST_PATTERN_EN
            logic [COUNTER_WIDTH-1:0] x_sr [PIXEL_LATENCY];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIXEL_LATENCY; i++) x_sr[i] <= '0;
                end else if (!video_enable) begin
                    for (int i = 0; i < PIXEL_LATENCY; i++) x_sr[i] <= '0;
                end else if (pixel_enable) begin
                    x_sr[0] <= x_counter;
                    for (int i = 1; i < PIXEL_LATENCY; i++) x_sr[i] <= x_sr[i-1];
                end
            end

            assign x_d = x_sr[PIXEL_LATENCY-1];
`endif
        end
    endgenerate

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_WIDTH = H_ACTIVE / 8;

    logic [2:0] bar_index;
    logic [2:0] bar_rgb;

    assign bar_index = 3'(x_d / COUNTER_WIDTH'(BAR_WIDTH));

    // {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        bar_rgb = 3'b000;
        case (bar_index)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    end

    assign src_red   = test_pattern_select ? {COLOR_WIDTH{bar_rgb[2]}} : pixel_red;
    assign src_green = test_pattern_select ? {COLOR_WIDTH{bar_rgb[1]}} : pixel_green;
    assign src_blue  = test_pattern_select ? {COLOR_WIDTH{bar_rgb[0]}} : pixel_blue;
`else
    logic unused_test_pattern_select;

    assign unused_test_pattern_select = test_pattern_select;
    assign src_red   = pixel_red;
    assign src_green = pixel_green;
    assign src_blue  = pixel_blue;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_red             <= '0;
            vga_green           <= '0;
            vga_blue            <= '0;
            vga_horizontal_sync <= ~H_SYNC_POLARITY;
            vga_vertical_sync   <= ~V_SYNC_POLARITY;
            vga_blank           <= 1'b0;
            vga_sync            <= 1'b0;
        end else if (!video_enable) begin
            vga_red             <= '0;
            vga_green           <= '0;
            vga_blue            <= '0;
            vga_horizontal_sync <= ~H_SYNC_POLARITY;
            vga_vertical_sync   <= ~V_SYNC_POLARITY;
            vga_blank           <= 1'b0;
            vga_sync            <= 1'b0;
        end else if (pixel_enable) begin
            vga_red             <= act_d ? src_red   : '0;
            vga_green           <= act_d ? src_green : '0;
            vga_blue            <= act_d ? src_blue  : '0;
            vga_horizontal_sync <= hs_d ? H_SYNC_POLARITY : ~H_SYNC_POLARITY;
            vga_vertical_sync   <= vs_d ? V_SYNC_POLARITY : ~V_SYNC_POLARITY;
            vga_blank           <= act_d;
            vga_sync            <= hs_d || vs_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator on a small 16x4 raster (24x8 total), 3-tick fetch latency.
module tb_vga_timing_generator;

    localparam int HA = 16, HFP = 2, HSP = 3, HBP = 3;
    localparam int VA = 4,  VFP = 1, VSP = 2, VBP = 1;
    localparam int HT = HA + HFP + HSP + HBP;
    localparam int VT = VA + VFP + VSP + VBP;
    localparam int FRAME = HT * VT;
    localparam int LAT = 3;
`ifdef VGA_TEST_PATTERN_EN
    localparam bit TP_EN = 1'b1;
`else
    localparam bit TP_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_enable = 1'b0;
    logic       video_enable = 1'b0;
    logic       test_pattern_select = 1'b0;
    logic [7:0] pixel_red, pixel_green, pixel_blue;
    logic [5:0] pixel_x_pos, pixel_y_pos;
    logic       pixel_request, line_start, frame_start;
    logic [7:0] vga_red, vga_green, vga_blue;
    logic       vga_clock, vga_horizontal_sync, vga_vertical_sync, vga_blank, vga_sync;

    int vectors = 0;
    int errors  = 0;
    int n       = 0;

    always #5 clock = ~clock;

    vga_timing_generator #(
        .H_ACTIVE(HA), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP),
        .V_ACTIVE(VA), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP),
        .H_SYNC_POLARITY(1'b0), .V_SYNC_POLARITY(1'b1),
        .COLOR_WIDTH(8), .COUNTER_WIDTH(6), .PIXEL_LATENCY(LAT)
    ) dut (
        .clock(clock), .reset(reset),
        .pixel_enable(pixel_enable), .video_enable(video_enable),
        .pixel_red(pixel_red), .pixel_green(pixel_green), .pixel_blue(pixel_blue),
        .test_pattern_select(test_pattern_select),
        .pixel_x_pos(pixel_x_pos), .pixel_y_pos(pixel_y_pos),
        .pixel_request(pixel_request), .line_start(line_start), .frame_start(frame_start),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .vga_clock(vga_clock),
        .vga_horizontal_sync(vga_horizontal_sync), .vga_vertical_sync(vga_vertical_sync),
        .vga_blank(vga_blank), .vga_sync(vga_sync)
    );

    // Framebuffer stand-in: returns the requested coordinates LAT enabled ticks later.
    logic [5:0] fx0, fx1, fx2, fy0, fy1, fy2;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {fx0, fx1, fx2, fy0, fy1, fy2} <= '0;
        end else if (pixel_enable && video_enable) begin
            fx0 <= pixel_x_pos; fx1 <= fx0; fx2 <= fx1;
            fy0 <= pixel_y_pos; fy1 <= fy0; fy2 <= fy1;
        end
    end
    assign pixel_red   = {2'b00, fx2};
    assign pixel_green = {2'b00, fx2} ^ 8'hA5;
    assign pixel_blue  = {2'b00, fy2};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    function automatic logic [2:0] bar(input int idx);
        case (idx)
            0: return 3'b111;  1: return 3'b110;  2: return 3'b011;  3: return 3'b010;
            4: return 3'b101;  5: return 3'b100;  6: return 3'b001;  default: return 3'b000;
        endcase
    endfunction

    // Expected values after n enabled ticks since the last clear.
    task automatic check_outputs();
        int cx, cy, ox, oy;
        bit act, oact, ohs, ovs;
        logic [7:0] er, eg, eb;
        logic [2:0] rgb;
        cx  = n % HT;
        cy  = (n / HT) % VT;
        act = (cx < HA) && (cy < VA);
        check("x_pos", 32'(pixel_x_pos), act ? cx : 0);
        check("y_pos", 32'(pixel_y_pos), act ? cy : 0);
        check("pixel_request", 32'(pixel_request), 32'(act));
        check("line_start", 32'(line_start), 32'(pixel_enable && video_enable && cx == 0));
        check("frame_start", 32'(frame_start), 32'(pixel_enable && video_enable && cx == 0 && cy == 0));
        ox = 0; oy = 0; oact = 0; ohs = 0; ovs = 0;
        if (n >= LAT + 1) begin
            ox   = (n - LAT - 1) % HT;
            oy   = ((n - LAT - 1) / HT) % VT;
            oact = (ox < HA) && (oy < VA);
            ohs  = (ox >= HA + HFP) && (ox < HA + HFP + HSP);
            ovs  = (oy >= VA + VFP) && (oy < VA + VFP + VSP);
        end
        er = oact ? 8'(ox) : 8'h00;
        eg = oact ? (8'(ox) ^ 8'hA5) : 8'h00;
        eb = oact ? 8'(oy) : 8'h00;
        if (TP_EN && test_pattern_select && oact) begin
            rgb = bar(ox / (HA / 8));
            er = {8{rgb[2]}}; eg = {8{rgb[1]}}; eb = {8{rgb[0]}};
        end
        check("vga_red", 32'(vga_red), 32'(er));
        check("vga_green", 32'(vga_green), 32'(eg));
        check("vga_blue", 32'(vga_blue), 32'(eb));
        check("hsync", 32'(vga_horizontal_sync), ohs ? 0 : 1);
        check("vsync", 32'(vga_vertical_sync), ovs ? 1 : 0);
        check("vga_blank", 32'(vga_blank), 32'(oact));
        check("vga_sync", 32'(vga_sync), 32'(ohs || ovs));
    endtask

    // Called in the low clock phase: drive, check, take one edge, return at the next negedge.
    task automatic step(input logic pe, input logic ve);
        pixel_enable = pe;
        video_enable = ve;
        #1;
        check_outputs();
        @(posedge clock);
        if (!ve) n = 0;
        else if (pe) n = n + 1;
        @(negedge clock);
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < 2 * FRAME && (n % FRAME) != pos; i++) step(1'b1, 1'b1);
        check("run_to_reached", 32'(n % FRAME), 32'(pos));
    endtask

    initial begin
        // Reset state with ticks enabled: markers follow the counters at 0.
        reset = 1'b1; pixel_enable = 1'b1; video_enable = 1'b1;
        @(negedge clock); #1;
        n = 0;
        check_outputs();
        check("vga_clock_low", 32'(vga_clock), 0);
        reset = 1'b0;

        // Two full frames plus wrap, every cycle enabled.
        for (int i = 0; i < 2 * FRAME + 8; i++) step(1'b1, 1'b1);

        // One enabled tick in four: outputs hold between ticks.
        for (int i = 0; i < 8 * HT; i++) step(i % 4 == 0, 1'b1);

        // Asynchronous reset in the middle of an active line (x=10, y=2).
        run_to(2 * HT + 10);
        #1;
        check_outputs();
        check("pre_reset_red", 32'(vga_red), 6);
        reset = 1'b1;
        #1;
        n = 0;
        check_outputs();
        @(negedge clock);
        check_outputs();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1);

        // video_enable dropped at the same point, then restored.
        run_to(2 * HT + 10);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1);

        // Colour-bar source (ignored when the feature is not built).
        reset = 1'b1;
        #1;
        n = 0;
        @(negedge clock);
        reset = 1'b0;
        test_pattern_select = 1'b1;
        for (int i = 0; i < VA * HT + LAT + 4; i++) step(1'b1, 1'b1);
        test_pattern_select = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Parametrised VGA timing generator and output stage for the video peripheral; successor to the fixed 640x480@60Hz driver.
- Timing, sync polarity, colour depth and pixel-fetch latency are set by parameters.
- Pixel rate is set by a clock-enable input, so it can run from the system clock.
- Produces pixel coordinates and frame/line markers for the framebuffer reader, and drives the ADV7123-style DAC interface with sync/blank delayed to match the framebuffer read latency.

Parameters:
- H_ACTIVE, 640, visible pixels per line (must be a multiple of 8)
- H_FRONT_PORCH, 16, pixels
- H_SYNC_PULSE, 96, pixels
- H_BACK_PORCH, 48, pixels
- V_ACTIVE, 480, visible lines
- V_FRONT_PORCH, 10, lines
- V_SYNC_PULSE, 2, lines
- V_BACK_PORCH, 33, lines
- H_SYNC_POLARITY, 0, active level of vga_horizontal_sync (0 = active-low)
- V_SYNC_POLARITY, 0, active level of vga_vertical_sync
- COLOR_WIDTH, 8, bits per colour channel
- COUNTER_WIDTH, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- PIXEL_LATENCY, 1, enabled ticks from coordinate output to valid pixel data input (0..15)

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- pixel_enable  input  1  pixel-rate tick; all timing state advances only when high
- video_enable  input  1  0 = counters held at 0, outputs blanked
- pixel_red / pixel_green / pixel_blue  input  COLOR_WIDTH each  pixel data, valid PIXEL_LATENCY ticks after its coordinates
- test_pattern_select  input  1  see Optional Feature
- pixel_x_pos  output  COUNTER_WIDTH  x coordinate (0 outside active area)
- pixel_y_pos  output  COUNTER_WIDTH  y coordinate (0 outside active area)
- pixel_request  output  1  coordinates are inside active area
- line_start  output  1  one-cycle pulse at x=0
- frame_start  output  1  one-cycle pulse at x=0, y=0
- vga_red / vga_green / vga_blue  output  COLOR_WIDTH each  DAC colour
- vga_clock  output  1  equal to clock
- vga_horizontal_sync  output  1  horizontal sync
- vga_vertical_sync  output  1  vertical sync
- vga_blank  output  1  DAC BLANK_n; 1 = active video
- vga_sync  output  1  composite sync; 1 during either sync pulse

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH
  - V_TOTAL likewise from the V_* parameters.
- Counters x_counter, y_counter:
  - Advance only on cycles with pixel_enable=1 and video_enable=1.
  - x wraps H_TOTAL-1 -> 0, and y increments on that wrap.
  - y wraps V_TOTAL-1 -> 0 when x wraps.
  - video_enable=0 resets both counters to 0 synchronously; so does reset (asynchronously).
- Region decode:
  - active = x<H_ACTIVE && y<V_ACTIVE.
  - hsync region: H_ACTIVE+H_FRONT_PORCH <= x < H_ACTIVE+H_FRONT_PORCH+H_SYNC_PULSE.
  - vsync region uses the V_* parameters the same way.
- Coordinate outputs (pixel_x_pos, pixel_y_pos, pixel_request) are combinational from the counters (latency 0).
- line_start and frame_start are combinational from the counters:
  - Gated with pixel_enable && video_enable, so each is exactly one clock wide per enabled tick.
- Delay line: active, hsync region and vsync region are shifted through PIXEL_LATENCY stages.
  - Stages shift only on enabled ticks.
  - PIXEL_LATENCY=0 means no stages.
- Output register: updates only on enabled ticks.
  - Colours are the pixel inputs when delayed active=1, else 0.
  - vga_horizontal_sync = H_SYNC_POLARITY when the delayed hsync region is set, else ~H_SYNC_POLARITY; vga_vertical_sync likewise.
  - vga_blank = delayed active.
  - vga_sync = delayed hsync region OR delayed vsync region.
  - Total: the DAC outputs lag the counters by PIXEL_LATENCY+1 enabled ticks.
- video_enable=0: the output register loads blank values (colour 0, sync inactive, vga_blank 0, vga_sync 0) on every cycle, and the delay line is cleared.
- Reset values:
  - Counters, coordinates, delay line and colours: 0.
  - vga_blank = 0 and vga_sync = 0.
  - Syncs at their inactive level.
  - pixel_request = 1 and frame_start/line_start follow their equations (counters at 0).
- Reset mid-line: all state returns to the reset values immediately. After release, the frame restarts at (0,0).

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: when test_pattern_select=1, the colour register ignores the pixel inputs and outputs 8 vertical bars.
  - Bar index = delayed x / (H_ACTIVE/8); the x coordinate is carried through the delay line.
  - Bar colours in order: white, yellow, cyan, green, magenta, red, blue, black (each channel all-ones or 0).
  - Bars are still blanked outside the active area.
- Undefined: test_pattern_select is ignored and no x delay line is built.

Test Plan:
- Defaults, pixel_enable=1, video_enable=1 after reset -> frame_start pulses exactly every 420000 cycles; line_start every 800 cycles.
- Defaults -> vga_horizontal_sync low for 96 cycles, first low cycle 2 cycles after x_counter=656. vga_vertical_sync low for 1600 cycles beginning with line 490.
- PIXEL_LATENCY=3, pixel data = x[7:0] on every channel -> vga_red equals the x coordinate shown 4 cycles earlier. Colours are 0 and vga_blank=0 at x>=640 or y>=480.
- pixel_enable high 1 cycle in 4 -> line period is 3200 cycles; all outputs hold between enabled ticks.
- Reset, or video_enable dropped, at x=300, y=100 -> counters 0, colours 0, syncs inactive. After release the next frame_start occurs on the first enabled tick.
- With VGA_TEST_PATTERN_EN and test_pattern_select=1 -> x=0..79 white, x=80..159 yellow, ... x=560..639 black (all 8 bars as listed under Optional Feature); 0 in blanking.
